// File: rtl/rans_decoder_pkg.sv
// rtl/rans_decoder_pkg.sv - shared state enum, default parameters and L/M derivations for the rANS decoder
`ifndef RANS_DECODER_PKG_SV
`define RANS_DECODER_PKG_SV

`define RANS_M(prob_bits) (1 << (prob_bits))
`define RANS_L(state_bits, in_width) (1 << ((state_bits) - (in_width)))

package rans_decoder_pkg;
   localparam int SYM_WIDTH_DEF  = 4;
   localparam int PROB_BITS_DEF  = 8;
   localparam int IN_WIDTH_DEF   = 8;
   localparam int STATE_BITS_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DECODE,
      RENORM
   } dec_state_t;
endpackage

`endif

// File: rtl/rans_decoder_if.sv
// rtl/rans_decoder_if.sv - bitstream-in and symbol-out handshakes of the rANS decoder
interface rans_decoder_if
   import rans_decoder_pkg::*;
#(
   parameter int SYM_WIDTH = SYM_WIDTH_DEF,
   parameter int IN_WIDTH  = IN_WIDTH_DEF
);
   logic [IN_WIDTH-1:0]  in;
   logic                 in_vld;
   logic                 in_rdy;
   logic [SYM_WIDTH-1:0] out;
   logic                 out_vld;
   logic                 out_rdy;

   // master is the environment (stream source and symbol sink), slave is the decoder
   modport master (output in, output in_vld, input in_rdy, input out, input out_vld, output out_rdy);
   modport slave  (input in, input in_vld, output in_rdy, output out, output out_vld, input out_rdy);
endinterface

// File: rtl/rans_sym_lookup.sv
// rtl/rans_sym_lookup.sv - frequency/cumulative table with write port and single-cycle slot-to-symbol search
module rans_sym_lookup
   import rans_decoder_pkg::*;
#(
   parameter int SYM_WIDTH = SYM_WIDTH_DEF,
   parameter int PROB_BITS = PROB_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 we,
   input  logic [SYM_WIDTH-1:0] addr,
   input  logic [PROB_BITS:0]   wr_freq,
   input  logic [PROB_BITS-1:0] wr_cum,
   input  logic [PROB_BITS-1:0] slot,
   output logic [SYM_WIDTH-1:0] sym,
   output logic [PROB_BITS:0]   sym_freq,
   output logic [PROB_BITS-1:0] sym_cum
);
   localparam int N = 1 << SYM_WIDTH;

   logic [PROB_BITS:0]   freq_q [N];
   logic [PROB_BITS-1:0] cum_q  [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            freq_q[i] <= '0;
            cum_q[i]  <= '0;
         end
      end else if (we) begin
         freq_q[addr] <= wr_freq;
         cum_q[addr]  <= wr_cum;
      end
   end

   // Ascending scan, so the highest used symbol whose cum <= slot wins.
   always_comb begin
      sym = '0;
      for (int i = 0; i < N; i++) begin
         if (freq_q[i] != '0 && cum_q[i] <= slot) sym = SYM_WIDTH'(i);
      end
   end

   assign sym_freq = freq_q[sym];
   assign sym_cum  = cum_q[sym];
endmodule

// File: rtl/rans_decoder.sv
// rtl/rans_decoder.sv - rANS stream decoder: frame FSM, state arithmetic and both handshakes
module rans_decoder
   import rans_decoder_pkg::*;
#(
   parameter int SYM_WIDTH  = SYM_WIDTH_DEF,
   parameter int PROB_BITS  = PROB_BITS_DEF,
   parameter int IN_WIDTH   = IN_WIDTH_DEF,
   parameter int STATE_BITS = STATE_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tbl_we,
   input  logic [SYM_WIDTH-1:0] tbl_addr,
   input  logic [PROB_BITS:0]   tbl_freq,
   input  logic [PROB_BITS-1:0] tbl_cum,
   input  logic                 start,
   input  logic [15:0]          frame_len,
   rans_decoder_if.slave        bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam int WORDS = STATE_BITS / IN_WIDTH;
   localparam int CW    = $clog2(WORDS + 1);
   localparam int XW    = STATE_BITS + 1;
   localparam logic [STATE_BITS-1:0] L = STATE_BITS'(`RANS_L(STATE_BITS, IN_WIDTH));

   dec_state_t            state, state_n;
   logic [STATE_BITS-1:0] x, x_next;
   logic [15:0]           remaining;
   logic [CW-1:0]         load_cnt;
   logic [SYM_WIDTH-1:0]  out_q;
   logic                  out_vld_q, done_q, err_q;
   logic                  in_rdy, in_fire, dec_fire;
   logic [PROB_BITS-1:0]  slot;
   logic [SYM_WIDTH-1:0]  sym;
   logic [PROB_BITS:0]    sym_freq;
   logic [PROB_BITS-1:0]  sym_cum;

   assign slot = x[PROB_BITS-1:0];

   rans_sym_lookup #(.SYM_WIDTH(SYM_WIDTH), .PROB_BITS(PROB_BITS)) u_lookup (
      .clk(clk), .rst_n(rst_n), .we(tbl_we && state == IDLE), .addr(tbl_addr),
      .wr_freq(tbl_freq), .wr_cum(tbl_cum), .slot(slot),
      .sym(sym), .sym_freq(sym_freq), .sym_cum(sym_cum)
   );

   // One extra bit of headroom for the product, then wrap to the state width.
   assign x_next = STATE_BITS'(XW'(sym_freq) * XW'(x >> PROB_BITS) + XW'(slot) - XW'(sym_cum));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      in_rdy   = 1'b0;
      dec_fire = 1'b0;
      case (state)
         IDLE:   if (start && frame_len != '0) state_n = LOAD;
         LOAD: begin
            in_rdy = 1'b1;
            if (bus.in_vld && load_cnt == CW'(WORDS - 1)) state_n = DECODE;
         end
         DECODE: if (!out_vld_q || bus.out_rdy) begin
            dec_fire = 1'b1;
            state_n  = (remaining == 16'd1) ? IDLE : RENORM;
         end
         RENORM: if (x < L) in_rdy = 1'b1;
                 else       state_n = DECODE;
         default: state_n = IDLE;
      endcase
   end

   assign in_fire = in_rdy && bus.in_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x         <= '0;
         remaining <= '0;
         load_cnt  <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state == IDLE && start && frame_len != '0) begin
            remaining <= frame_len;
            err_q     <= 1'b0;
            load_cnt  <= '0;
         end
         if (in_fire) begin
            x <= {x[STATE_BITS-IN_WIDTH-1:0], bus.in};
            if (state == LOAD) load_cnt <= load_cnt + CW'(1);
         end
         // A new symbol overrides the clear so out_vld stays high across back-to-back handoffs.
         if (dec_fire) begin
            out_q     <= sym;
            out_vld_q <= 1'b1;
            x         <= x_next;
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
               done_q <= 1'b1;
               err_q  <= (x_next != L);
            end
         end else if (out_vld_q && bus.out_rdy) begin
            out_vld_q <= 1'b0;
         end
      end
   end

   assign bus.in_rdy  = in_rdy;
   assign bus.out     = out_q;
   assign bus.out_vld = out_vld_q;
   assign busy        = (state != IDLE);
   assign done        = done_q;
   assign err         = err_q;
endmodule

// File: tb/tb_rans_decoder.sv
// tb/tb_rans_decoder.sv - table-driven and randomized self-checking bench for rans_decoder
`timescale 1ns/1ps
module tb_rans_decoder;
   import rans_decoder_pkg::*;

   localparam int SW = 4, PB = 8, IW = 8, SB = 16, N = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              tbl_we = 1'b0;
   logic [SW-1:0]     tbl_addr = '0;
   logic [PB:0]       tbl_freq = '0;
   logic [PB-1:0]     tbl_cum = '0;
   logic              start = 1'b0;
   logic [15:0]       frame_len = '0;
   logic              busy, done, err;

   rans_decoder_if #(.SYM_WIDTH(SW), .IN_WIDTH(IW)) bus();

   rans_decoder #(.SYM_WIDTH(SW), .PROB_BITS(PB), .IN_WIDTH(IW), .STATE_BITS(SB)) dut (
      .clk(clk), .rst_n(rst_n), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_freq(tbl_freq),
      .tbl_cum(tbl_cum), .start(start), .frame_len(frame_len), .bus(bus),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tbl; bit reload; int len; int nw; int words; int in_mode; int out_mode; bit junk;
      int nsym; int syms; int exp_words; bit exp_err;
   } vec_t;

   vec_t vecs[7];
   int   checks = 0, errors = 0;
   int   mfreq[N], mcum[N];
   int   stream_q[$], exp_q[$], got_q[$];
   int   exp_words;
   bit   exp_err;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " out"}, bus.out, 0);
      chk({tag, " out_vld"}, bus.out_vld, 0);
      chk({tag, " in_rdy"}, bus.in_rdy, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " err"}, err, 0);
   endtask

   task automatic load_table(input int id);
      int mask, k, left, acc, f;
      for (int i = 0; i < N; i++) begin mfreq[i] = 0; mcum[i] = 0; end
      if (id == 0) mfreq[3] = 256;
      else if (id == 1) begin mfreq[0] = 128; mfreq[1] = 128; mcum[1] = 128; end
      else begin
         // random partition of M=256 over a nonempty subset; unused entries get junk cum
         mask = $urandom_range(1, 65535);
         k = 0;
         for (int i = 0; i < N; i++) if (mask[i]) k++;
         left = 256; acc = 0;
         for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
               k--;
               f = (k == 0) ? left : $urandom_range(1, (left - k + 1) / 2);
               mfreq[i] = f; mcum[i] = acc; acc += f; left -= f;
            end else mcum[i] = $urandom_range(0, 255);
         end
      end
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         tbl_we = 1'b1; tbl_addr = SW'(i); tbl_freq = (PB+1)'(mfreq[i]); tbl_cum = PB'(mcum[i]);
      end
      @(negedge clk);
      tbl_we = 1'b0;
   endtask

   task automatic model(input int n);
      int x = 0, p = 0, slot, s;
      exp_q.delete();
      for (int k = 0; k < 2; k++) x = x * 256 + stream_q[p++];
      for (int i = 0; i < n; i++) begin
         slot = x % 256;
         s = 0;
         for (int t = 0; t < N; t++)
            if (mfreq[t] > 0 && slot >= mcum[t] && slot < mcum[t] + mfreq[t]) s = t;
         exp_q.push_back(s);
         x = (mfreq[s] * (x / 256) + slot - mcum[s]) % 65536;
         if (i < n - 1)
            while (x < 256 && p < stream_q.size()) x = x * 256 + stream_q[p++];
      end
      exp_words = p;
      exp_err = (x != 256);
   endtask

   task automatic run_frame(input int n, input int in_mode, input int out_mode, input bit junk, input string tag);
      int idx = 0, cyc = 0, gap_left = 0, stall_left = 0, held = 0, done_cnt = 0;
      bit gap0 = 0, gap2 = 0, gap_load = 0, stalled = 0, finished = 0, err_at_done = 0;
      got_q.delete();
      @(negedge clk); frame_len = 16'(n); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({tag, " busy_after_start"}, busy, 1);
      chk({tag, " in_rdy_after_start"}, bus.in_rdy, 1);
      while (!finished && cyc < 3000) begin
         if (in_mode == 2 && bus.in_rdy && ((idx == 0 && !gap0) || (idx == 2 && !gap2))) begin
            gap_left = 3; gap_load = (idx == 0);
            if (idx == 0) gap0 = 1; else gap2 = 1;
         end
         bus.in_vld = (gap_left == 0) && (in_mode != 1 || $urandom_range(0, 3) != 0);
         bus.in = (idx < stream_q.size()) ? IW'(stream_q[idx]) : IW'($urandom);
         if (out_mode == 2 && !stalled && bus.out_vld) begin
            stalled = 1; stall_left = 5; held = int'(bus.out);
         end
         bus.out_rdy = (stall_left == 0) && (out_mode != 1 || $urandom_range(0, 1) == 1);
         if (junk && cyc == 3) begin
            tbl_we = 1'b1; tbl_addr = SW'(1); tbl_freq = '0; tbl_cum = '0; start = 1'b1; frame_len = 16'd9;
         end else begin
            tbl_we = 1'b0; start = 1'b0;
         end
         #4;
         if (bus.in_vld && bus.in_rdy) idx++;
         if (bus.out_vld && bus.out_rdy) got_q.push_back(int'(bus.out));
         if (gap_left > 0) begin
            chk({tag, " starve_in_rdy"}, bus.in_rdy, 1);
            if (gap_load) chk({tag, " starve_no_out_vld"}, bus.out_vld, 0);
            gap_left--;
         end
         if (stall_left > 0) begin
            chk({tag, " hold_out_vld"}, bus.out_vld, 1);
            chk({tag, " hold_out"}, bus.out, held);
            stall_left--;
            if (stall_left == 0) chk({tag, " renorm_during_stall"}, idx, exp_words);
         end
         if (done) begin
            done_cnt++;
            err_at_done = err;
            chk({tag, " busy_at_done"}, busy, 0);
         end
         finished = (done_cnt > 0) && !bus.out_vld;
         @(negedge clk);
         cyc++;
      end
      bus.in_vld = 1'b0; bus.out_rdy = 1'b0; tbl_we = 1'b0; start = 1'b0;
      chk({tag, " frame_completes"}, finished, 1);
      chk({tag, " done_count"}, done_cnt, 1);
      chk({tag, " words_consumed"}, idx, exp_words);
      chk({tag, " symbol_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s sym[%0d]", tag, i), got_q[i], exp_q[i]);
      chk({tag, " err_at_done"}, err_at_done, exp_err);
      chk({tag, " err_held"}, err, exp_err);
   endtask

   task automatic run_vec(input int v, input string tag);
      if (vecs[v].reload) load_table(vecs[v].tbl);
      stream_q.delete();
      for (int k = 0; k < vecs[v].nw; k++)
         stream_q.push_back((vecs[v].words >> (8 * (vecs[v].nw - 1 - k))) & 255);
      exp_q.delete();
      for (int k = 0; k < vecs[v].nsym; k++) exp_q.push_back((vecs[v].syms >> (4 * k)) & 15);
      exp_words = vecs[v].exp_words;
      exp_err = vecs[v].exp_err;
      run_frame(vecs[v].len, vecs[v].in_mode, vecs[v].out_mode, vecs[v].junk, tag);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0] = '{tbl:0, reload:1, len:4, nw:2, words:32'h0100,   in_mode:0, out_mode:0, junk:0, nsym:4, syms:16'h3333, exp_words:2, exp_err:0};
      vecs[1] = '{tbl:1, reload:1, len:2, nw:3, words:32'h01FF80, in_mode:0, out_mode:0, junk:0, nsym:2, syms:16'h0011, exp_words:3, exp_err:1};
      vecs[2] = '{tbl:1, reload:0, len:2, nw:3, words:32'h01FF80, in_mode:0, out_mode:2, junk:0, nsym:2, syms:16'h0011, exp_words:3, exp_err:1};
      vecs[3] = '{tbl:1, reload:0, len:2, nw:3, words:32'h01FF80, in_mode:2, out_mode:0, junk:0, nsym:2, syms:16'h0011, exp_words:3, exp_err:1};
      vecs[4] = '{tbl:1, reload:0, len:2, nw:3, words:32'h01FF80, in_mode:0, out_mode:0, junk:1, nsym:2, syms:16'h0011, exp_words:3, exp_err:1};
      vecs[5] = '{tbl:1, reload:0, len:2, nw:3, words:32'h01FF80, in_mode:1, out_mode:1, junk:0, nsym:2, syms:16'h0011, exp_words:3, exp_err:1};
      vecs[6] = '{tbl:0, reload:1, len:4, nw:2, words:32'h0100,   in_mode:1, out_mode:1, junk:0, nsym:4, syms:16'h3333, exp_words:2, exp_err:0};

      bus.in = '0; bus.in_vld = 1'b0; bus.out_rdy = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 7; v++) run_vec(v, $sformatf("vec%0d", v));

      @(negedge clk); start = 1'b1; frame_len = 16'd0;
      @(negedge clk); start = 1'b0;
      chk("zero_len busy", busy, 0);
      chk("zero_len in_rdy", bus.in_rdy, 0);

      for (int r = 0; r < 25; r++) begin
         if (r % 5 == 0) load_table(2);
         n = $urandom_range(1, 20);
         stream_q.delete();
         stream_q.push_back($urandom_range(1, 255));
         for (int k = 0; k < n + 1; k++) stream_q.push_back($urandom_range(0, 255));
         model(n);
         run_frame(n, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, $sformatf("rand%0d", r));
      end

      load_table(1);
      @(negedge clk); start = 1'b1; frame_len = 16'd2;
      @(negedge clk); start = 1'b0; bus.in = 8'h01; bus.in_vld = 1'b1;
      @(negedge clk); bus.in = 8'hFF;
      @(negedge clk); bus.in_vld = 1'b0;
      @(negedge clk);
      chk("pre_reset renorm in_rdy", bus.in_rdy, 1);
      chk("pre_reset out_vld", bus.out_vld, 1);
      #2 rst_n = 1'b0;
      #1;
      check_reset("mid_reset");
      chk("mid_reset freq0", dut.u_lookup.freq_q[0], 0);
      chk("mid_reset freq1", dut.u_lookup.freq_q[1], 0);
      @(negedge clk); rst_n = 1'b1;
      run_vec(1, "after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
